// File: rtl/serial_adder_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell and a carry flop, one bit per clock, LSB first.
// Optional accumulate mode (A loaded from the last result) is enabled by defining SERIAL_ADDER_ACC_EN.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iStart,
    input  logic             iSub,
`ifdef SERIAL_ADDER_ACC_EN
    input  logic             iAcc,
`endif
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oSum,
    output logic             oCarryout,
    output logic             oOverflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_sum;
    logic             cell_cout;
    logic [WIDTH-1:0] load_a;

    assign cell_sum  = a_q[0] ^ b_q[0] ^ carry_q;
    assign cell_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

`ifdef SERIAL_ADDER_ACC_EN
    assign load_a = iAcc ? sum_q : iA;
`else
    assign load_a = iA;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                if (iStart) begin
                    a_d     = load_a;
                    b_d     = iB ^ {WIDTH{iSub}};
                    carry_d = iSub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {cell_sum, res_q[WIDTH-1:1]};
                carry_d = cell_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // carry_q is the carry into the MSB on the last bit.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {cell_sum, res_q[WIDTH-1:1]};
                    cout_d  = cell_cout;
                    ovf_d   = carry_q ^ cell_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oBusy     = (state_q == RUN);
    assign oDone     = (state_q == DONE);
    assign oSum      = sum_q;
    assign oCarryout = cout_q;
    assign oOverflow = ovf_q;

endmodule
